dmem_wait_ctrl: RTL and testbench

//  Multi-cycle data memory with wait-state handshake; replaces the zero-latency data memory

---
 rtl/dmem_wait_ctrl.sv | 138 +++++++++++++
 tb/tb_dmem_wait_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_ctrl.sv
// Word-addressed data memory with a fixed wait-state handshake: every load/store
// holds stall_o high for LATENCY cycles, then commits and retires in a DONE cycle.
module dmem_wait_ctrl #(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic [31:0] data_o,
  output logic        stall_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic [31:0]        data_q;
  logic [31:0]        mem [DEPTH];

  logic               req;
  logic               commit;
  logic               c_wr;
  logic               c_rd;
  logic [IDX_W-1:0]   c_idx;
  logic [31:0]        c_data;

  // Byte offset and bits above the index are don't-care (word aligned, wraps modulo DEPTH).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

  assign req     = MemRead_i | MemWrite_i;
  assign stall_o = req & (state_q != S_DONE);
  assign data_o  = data_q;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    commit  = 1'b0;
    c_wr    = wr_q;
    c_rd    = rd_q;
    c_idx   = idx_q;
    c_data  = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = addr_i[IDX_W+1:2];
          wdata_d = data_i;
          wr_d    = MemWrite_i;
          // A simultaneous read and write is treated as a pure write.
          rd_d    = MemRead_i & ~MemWrite_i;
          cnt_d   = CNT_W'(1);
          if (LATENCY == 1) begin
            // Single-cycle wait: commit straight from the live inputs.
            state_d = S_DONE;
            commit  = 1'b1;
            c_wr    = wr_d;
            c_rd    = rd_d;
            c_idx   = idx_d;
            c_data  = wdata_d;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (commit && c_rd) begin
        data_q <= mem[c_idx];
      end
    end
  end

  // NOTE: the array must come up cleared, so it is reset word by word (flop array, not an SRAM macro).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (commit && c_wr) begin
      mem[c_idx] <= c_data;
    end
  end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl: LATENCY=3 main instance plus LATENCY=1 and
// LATENCY=5 instances sharing the same request bus for the latency scaling checks.
module tb_dmem_wait_ctrl;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] data1, data3, data5;
  logic        stall1, stall3, stall5;

  int          sel;
  logic        stall_w;
  logic [31:0] data_w;

  int errors = 0;
  int checks = 0;

  dmem_wait_ctrl #(.DEPTH(128), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata),
    .MemRead_i(rd), .MemWrite_i(wr), .data_o(data3), .stall_o(stall3)
  );

  dmem_wait_ctrl #(.DEPTH(128), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata),
    .MemRead_i(rd), .MemWrite_i(wr), .data_o(data1), .stall_o(stall1)
  );

  dmem_wait_ctrl #(.DEPTH(128), .LATENCY(5)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata),
    .MemRead_i(rd), .MemWrite_i(wr), .data_o(data5), .stall_o(stall5)
  );

  assign stall_w = (sel == 1) ? stall1 : (sel == 5) ? stall5 : stall3;
  assign data_w  = (sel == 1) ? data1  : (sel == 5) ? data5  : data3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    rd  = 1'b0;
    wr  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request in the next cycle and returns in its DONE cycle (first stall_o=0),
  // reporting the cycles from request to DONE inclusive; 50 means the wait timed out.
  task automatic mem_op(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int cycles);
    @(negedge clk);
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    cycles = 1;
    #1;
    while (stall_w && cycles < 50) begin
      @(negedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic test_reset();
    sel = 3;
    reset_dut();
    #1;
    checks++;
    if (data3 !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected %h", data3, 32'h0);
    end
    checks++;
    if (stall3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 0", stall3);
    end
  endtask

  task automatic test_load_basic();
    int c;
    mem_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, c);
    checks++;
    if (c != 4) begin
      errors++;
      $display("FAIL lw_basic_cycles: got %0d expected 4", c);
    end
    checks++;
    if (data3 !== 32'h0) begin
      errors++;
      $display("FAIL lw_basic_data: got %h expected %h", data3, 32'h0);
    end
    go_idle();
  endtask

  task automatic test_store_load();
    int c;
    mem_op(1'b0, 1'b1, 32'h24, 32'hDEAD_BEEF, c);
    checks++;
    if (c != 4) begin
      errors++;
      $display("FAIL sw_cycles: got %0d expected 4", c);
    end
    mem_op(1'b1, 1'b0, 32'h24, 32'h0, c);
    checks++;
    if (c != 4) begin
      errors++;
      $display("FAIL lw_after_sw_cycles: got %0d expected 4", c);
    end
    checks++;
    if (data3 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL lw_after_sw_data: got %h expected %h", data3, 32'hDEAD_BEEF);
    end
    go_idle();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (data3 !== 32'hDEAD_BEEF || stall3 !== 1'b0) begin
      errors++;
      $display("FAIL data_hold: got data=%h stall=%b expected data=%h stall=0",
               data3, stall3, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_wrap();
    int c;
    logic [31:0] exp_data [4] = '{32'h1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
    logic [31:0] rd_addr  [4] = '{32'h0, 32'h27, 32'h1_0024, 32'h1FC};
    mem_op(1'b0, 1'b1, 32'h200, 32'h1, c);
    for (int i = 0; i < 4; i++) begin
      mem_op(1'b1, 1'b0, rd_addr[i], 32'h0, c);
      checks++;
      if (data3 !== exp_data[i]) begin
        errors++;
        $display("FAIL wrap_lw[%0h]: got %h expected %h", rd_addr[i], data3, exp_data[i]);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid_access();
    int c;
    @(negedge clk);
    wr    = 1'b1;
    rd    = 1'b0;
    addr  = 32'h8;
    wdata = 32'h55;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wr  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (data3 !== 32'h0 || stall3 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out: got data=%h stall=%b expected data=0 stall=0", data3, stall3);
    end
    mem_op(1'b1, 1'b0, 32'h8, 32'h0, c);
    checks++;
    if (c != 4 || data3 !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_lw8: got cycles=%0d data=%h expected cycles=4 data=0", c, data3);
    end
    mem_op(1'b1, 1'b0, 32'h24, 32'h0, c);
    checks++;
    if (data3 !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_cleared: got %h expected %h", data3, 32'h0);
    end
    go_idle();
  endtask

  task automatic test_read_write_both();
    int c;
    mem_op(1'b0, 1'b1, 32'h40, 32'h99, c);
    mem_op(1'b1, 1'b0, 32'h40, 32'h0, c);
    mem_op(1'b1, 1'b1, 32'hC, 32'h77, c);
    checks++;
    if (c != 4 || data3 !== 32'h99) begin
      errors++;
      $display("FAIL rw_both: got cycles=%0d data=%h expected cycles=4 data=%h", c, data3, 32'h99);
    end
    mem_op(1'b1, 1'b0, 32'hC, 32'h0, c);
    checks++;
    if (data3 !== 32'h77) begin
      errors++;
      $display("FAIL rw_both_lw: got %h expected %h", data3, 32'h77);
    end
    go_idle();
  endtask

  task automatic test_non_mem();
    int c;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rd    = 1'b0;
      wr    = 1'b0;
      addr  = $urandom;
      wdata = $urandom;
      #1;
      checks++;
      if (stall3 !== 1'b0 || data3 !== 32'h77) begin
        errors++;
        $display("FAIL non_mem[%0d]: got stall=%b data=%h expected stall=0 data=%h",
                 i, stall3, data3, 32'h77);
      end
    end
    mem_op(1'b1, 1'b0, 32'h40, 32'h0, c);
    checks++;
    if (c != 4 || data3 !== 32'h99) begin
      errors++;
      $display("FAIL non_mem_then_lw: got cycles=%0d data=%h expected cycles=4 data=%h", c, data3, 32'h99);
    end
    go_idle();
  endtask

  task automatic test_busy_tolerance();
    int c;
    @(negedge clk);
    wr    = 1'b1;
    rd    = 1'b0;
    addr  = 32'h30;
    wdata = 32'h11;
    @(negedge clk);
    addr  = 32'h34;
    wdata = 32'h22;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (stall3 !== 1'b0) begin
      errors++;
      $display("FAIL busy_done_stall: got %b expected 0", stall3);
    end
    mem_op(1'b1, 1'b0, 32'h30, 32'h0, c);
    checks++;
    if (data3 !== 32'h11) begin
      errors++;
      $display("FAIL busy_latched_lw30: got %h expected %h", data3, 32'h11);
    end
    mem_op(1'b1, 1'b0, 32'h34, 32'h0, c);
    checks++;
    if (data3 !== 32'h0) begin
      errors++;
      $display("FAIL busy_latched_lw34: got %h expected %h", data3, 32'h0);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int c;
    int total;
    total = 0;
    mem_op(1'b0, 1'b1, 32'h100, 32'hA5A5_0001, c);
    total += c;
    mem_op(1'b0, 1'b1, 32'h104, 32'h5A5A_0002, c);
    total += c;
    mem_op(1'b1, 1'b0, 32'h100, 32'h0, c);
    total += c;
    checks++;
    if (data3 !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL b2b_lw100: got %h expected %h", data3, 32'hA5A5_0001);
    end
    mem_op(1'b1, 1'b0, 32'h104, 32'h0, c);
    total += c;
    checks++;
    if (data3 !== 32'h5A5A_0002) begin
      errors++;
      $display("FAIL b2b_lw104: got %h expected %h", data3, 32'h5A5A_0002);
    end
    checks++;
    if (total != 16) begin
      errors++;
      $display("FAIL b2b_total_cycles: got %0d expected 16", total);
    end
    go_idle();
  endtask

  task automatic test_latency(input int lat);
    int c;
    sel = lat;
    reset_dut();
    mem_op(1'b0, 1'b1, 32'h50, 32'hCAFE_0000 + lat, c);
    checks++;
    if (c != lat + 1) begin
      errors++;
      $display("FAIL lat%0d_sw_cycles: got %0d expected %0d", lat, c, lat + 1);
    end
    mem_op(1'b1, 1'b0, 32'h50, 32'h0, c);
    checks++;
    if (c != lat + 1 || data_w !== 32'hCAFE_0000 + lat) begin
      errors++;
      $display("FAIL lat%0d_lw: got cycles=%0d data=%h expected cycles=%0d data=%h",
               lat, c, data_w, lat + 1, 32'hCAFE_0000 + lat);
    end
    go_idle();
  endtask

  initial begin
    rst   = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    sel   = 3;
    test_reset();
    test_load_basic();
    test_store_load();
    test_wrap();
    test_reset_mid_access();
    test_read_write_both();
    test_non_mem();
    test_busy_tolerance();
    test_back_to_back();
    test_latency(1);
    test_latency(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
